// File: rtl/fifo_stream_pkg.sv
// Shared defaults and types for the FIFO drain / stream reader slice.
package fifo_stream_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SKID_DEPTH_DEF = 4;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer that absorbs words arriving one cycle after each FIFO read.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = SKID_DEPTH_DEF,
    parameter int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [OCC_W-1:0]      occ_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer only lands if the same cycle frees a slot.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream, hiding the one-cycle read latency.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SKID_DEPTH = SKID_DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic                  ovf_err
);

    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    logic                 pend_q;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 ovf_err_q, ovf_err_d;
    logic [OCC_W-1:0]     occ;
    logic                 buf_full;
    logic                 buf_empty;
    logic                 pop;
    logic [OCC_W:0]       inflight;

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH),
        .OCC_W      (OCC_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pend_q),
        .data_i  (fifo_dout),
        .pop_i   (pop),
        .head_o  (m_data),
        .occ_o   (occ),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Reads are throttled by buffered plus in-flight words only, never by m_ready,
    // so every issued read is guaranteed a slot; reset gating keeps the strobe quiet.
    assign inflight  = {1'b0, occ} + {{OCC_W{1'b0}}, pend_q};
    assign fifo_read = reset & enable & ~fifo_empty & (inflight < (OCC_W + 1)'(SKID_DEPTH));

    assign m_valid  = ~buf_empty;
    assign pop      = m_valid & m_ready;
    assign beat_cnt = beat_cnt_q;
    assign ovf_err  = ovf_err_q;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        ovf_err_d  = ovf_err_q;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
        if (pend_q & buf_full & ~pop) begin
            ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q     <= 1'b0;
            beat_cnt_q <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            pend_q     <= fifo_read;
            beat_cnt_q <= beat_cnt_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed, table-driven bench for fifo_stream_reader with a behavioural FIFO and stream monitor.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_read;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [15:0] beat_cnt;
    logic        ovf_err;

    fifo_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .beat_cnt   (beat_cnt),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered dout, combinational empty.
    logic [7:0] fifoMem [256];
    int         headIdx = 0;
    int         tailIdx = 0;
    logic       fifoFlush = 1'b0;

    assign fifo_empty = (headIdx == tailIdx);

    always @(posedge clk) begin
        if (fifoFlush) begin
            headIdx <= tailIdx;
        end else if (fifo_read && !fifo_empty) begin
            fifo_dout <= fifoMem[headIdx & 255];
            headIdx   <= headIdx + 1;
        end
    end

    // Stream monitor.
    logic [7:0] gotQ [$];
    int         cyc = 0;
    int         readCount = 0;
    int         firstReadCyc = -1;
    int         lastReadCyc = -1;
    int         firstBeatCyc = -1;
    int         lastBeatCyc = -1;
    int         emptyReadViol = 0;
    int         stallViol = 0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (fifo_read) begin
            if (firstReadCyc < 0) firstReadCyc = cyc;
            lastReadCyc = cyc;
            readCount = readCount + 1;
            if (fifo_empty) emptyReadViol = emptyReadViol + 1;
        end
        if (m_valid && m_ready) begin
            gotQ.push_back(m_data);
            if (firstBeatCyc < 0) firstBeatCyc = cyc;
            lastBeatCyc = cyc;
        end
        if (prevStall && m_valid && (m_data != prevData)) stallViol = stallViol + 1;
        prevStall = m_valid && !m_ready;
        prevData  = m_data;
    end

    int compareCount = 0;
    int failCount = 0;

    typedef struct {
        int         nWords;
        int         stallCycles;
        logic       en;
        logic [7:0] base;
        int         expReads;
        int         expBeats;
    } vec_t;

    vec_t vecs [5];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount = compareCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        gotQ.delete();
        readCount    = 0;
        firstReadCyc = -1;
        lastReadCyc  = -1;
        firstBeatCyc = -1;
        lastBeatCyc  = -1;
    endtask

    task automatic loadWords(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fifoMem[(tailIdx + i) & 255] = base + 8'(i);
        end
        tailIdx = tailIdx + n;
    endtask

    task automatic doReset();
        reset     = 1'b0;
        enable    = 1'b0;
        m_ready   = 1'b0;
        fifoFlush = 1'b1;
        tick();
        fifoFlush = 1'b0;
        tick();
        reset = 1'b1;
        clearMonitor();
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int readsWindow;
        doReset();
        loadWords(v.nWords, v.base);
        enable  = v.en;
        m_ready = 1'b0;
        tick(v.stallCycles);
        readsWindow = readCount;
        m_ready = 1'b1;
        tick(40);
        enable = 1'b0;
        checkOutput({tag, ".readsStalled"}, 32'(readsWindow), 32'(v.expReads));
        checkOutput({tag, ".beatCnt"}, 32'(beat_cnt), 32'(v.expBeats));
        checkOutput({tag, ".delivered"}, 32'(gotQ.size()), 32'(v.expBeats));
        for (int i = 0; i < v.expBeats; i++) begin
            if (i < gotQ.size()) checkOutput({tag, ".word"}, 32'(gotQ[i]), 32'(v.base + 8'(i)));
        end
        checkOutput({tag, ".ovfErr"}, 32'(ovf_err), 32'(0));
    endtask

    initial begin
        vecs[0] = '{nWords: 1,  stallCycles: 0,  en: 1'b1, base: 8'h50, expReads: 0, expBeats: 1};
        vecs[1] = '{nWords: 16, stallCycles: 20, en: 1'b1, base: 8'h80, expReads: 4, expBeats: 16};
        vecs[2] = '{nWords: 3,  stallCycles: 10, en: 1'b1, base: 8'hC0, expReads: 3, expBeats: 3};
        vecs[3] = '{nWords: 5,  stallCycles: 0,  en: 1'b0, base: 8'h10, expReads: 0, expBeats: 0};
        vecs[4] = '{nWords: 8,  stallCycles: 8,  en: 1'b1, base: 8'hF8, expReads: 4, expBeats: 8};

        reset   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        tick(2);

        // Reset hold with a non-empty FIFO and enable high.
        loadWords(2, 8'h11);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst.fifoRead", 32'(fifo_read), 32'(0));
            checkOutput("rst.mValid", 32'(m_valid), 32'(0));
            checkOutput("rst.beatCnt", 32'(beat_cnt), 32'(0));
            tick();
        end
        checkOutput("rst.mData", 32'(m_data), 32'(0));
        checkOutput("rst.ovfErr", 32'(ovf_err), 32'(0));
        reset = 1'b1;
        #1;
        checkOutput("rst.firstRead", 32'(fifo_read), 32'(1));

        // Single word latency.
        doReset();
        enable  = 1'b1;
        m_ready = 1'b1;
        loadWords(1, 8'hA5);
        #1;
        checkOutput("single.readT", 32'(fifo_read), 32'(1));
        tick();
        checkOutput("single.readT1", 32'(fifo_read), 32'(0));
        checkOutput("single.validT1", 32'(m_valid), 32'(0));
        tick();
        checkOutput("single.validT2", 32'(m_valid), 32'(1));
        checkOutput("single.dataT2", 32'(m_data), 32'(8'hA5));
        tick();
        checkOutput("single.validT3", 32'(m_valid), 32'(0));
        checkOutput("single.beatCnt", 32'(beat_cnt), 32'(1));

        // Streaming at full rate.
        doReset();
        loadWords(16, 8'h00);
        m_ready = 1'b1;
        enable  = 1'b1;
        tick(25);
        checkOutput("stream.reads", 32'(readCount), 32'(16));
        checkOutput("stream.readSpan", 32'(lastReadCyc - firstReadCyc), 32'(15));
        checkOutput("stream.beatSpan", 32'(lastBeatCyc - firstBeatCyc), 32'(15));
        checkOutput("stream.beatCnt", 32'(beat_cnt), 32'(16));
        checkOutput("stream.count", 32'(gotQ.size()), 32'(16));
        for (int i = 0; i < 16; i++) begin
            if (i < gotQ.size()) checkOutput("stream.word", 32'(gotQ[i]), 32'(i));
        end
        checkOutput("stream.ovfErr", 32'(ovf_err), 32'(0));

        // Backpressure: buffer fills to four and holds its head steady.
        doReset();
        loadWords(16, 8'h00);
        enable = 1'b1;
        tick(20);
        checkOutput("bp.reads", 32'(readCount), 32'(4));
        checkOutput("bp.readHeld", 32'(fifo_read), 32'(0));
        checkOutput("bp.mValid", 32'(m_valid), 32'(1));
        checkOutput("bp.mData", 32'(m_data), 32'(0));
        m_ready = 1'b1;
        tick(30);
        checkOutput("bp.count", 32'(gotQ.size()), 32'(16));
        for (int i = 0; i < 16; i++) begin
            if (i < gotQ.size()) checkOutput("bp.word", 32'(gotQ[i]), 32'(i));
        end
        checkOutput("bp.stallStable", 32'(stallViol), 32'(0));

        // Enable drops the cycle after the only read.
        doReset();
        enable  = 1'b1;
        m_ready = 1'b1;
        loadWords(1, 8'h3C);
        tick();
        enable = 1'b0;
        loadWords(1, 8'h77);
        tick(6);
        checkOutput("en.reads", 32'(readCount), 32'(1));
        checkOutput("en.count", 32'(gotQ.size()), 32'(1));
        if (gotQ.size() > 0) checkOutput("en.word", 32'(gotQ[0]), 32'(8'h3C));
        checkOutput("en.noReadEmpty", 32'(emptyReadViol), 32'(0));

        // Asynchronous reset with three buffered words and one in flight.
        doReset();
        loadWords(16, 8'h20);
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(5);
        checkOutput("mid.beatsBefore", 32'(beat_cnt), 32'(3));
        m_ready = 1'b0;
        tick(2);
        checkOutput("mid.validBefore", 32'(m_valid), 32'(1));
        checkOutput("mid.readStopped", 32'(fifo_read), 32'(0));
        #3;
        reset = 1'b0;
        #1;
        checkOutput("mid.validAfter", 32'(m_valid), 32'(0));
        checkOutput("mid.beatCntAfter", 32'(beat_cnt), 32'(0));
        checkOutput("mid.mDataAfter", 32'(m_data), 32'(0));
        enable    = 1'b0;
        fifoFlush = 1'b1;
        tick();
        fifoFlush = 1'b0;
        tick();
        reset   = 1'b1;
        m_ready = 1'b1;
        enable  = 1'b1;
        clearMonitor();
        tick(6);
        checkOutput("mid.noStale", 32'(gotQ.size()), 32'(0));
        checkOutput("mid.validIdle", 32'(m_valid), 32'(0));

        // Table-driven scenarios.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v], $sformatf("vec%0d", v));
        end

        checkOutput("all.noReadEmpty", 32'(emptyReadViol), 32'(0));
        checkOutput("all.stallStable", 32'(stallViol), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
